// File: rtl/ciclo_bus_rtc.sv
// Multiplexed AD-bus cycle generator for an external RTC: address phase with ALE,
// then a timed read or write strobe, every phase lasting T_PULSO clocks.
module ciclo_bus_rtc #(
  parameter int unsigned T_PULSO = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activa,
  input  logic       w,
  input  logic [7:0] dir,
  input  logic [7:0] dato_esc,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ale,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] dato_lec,
  output logic       fin,
  output logic       ocupado
);

  localparam int unsigned T_EFF    = (T_PULSO == 0) ? 1 : T_PULSO;
  localparam logic [7:0]  CNT_LOAD = 8'(T_EFF - 1);

  typedef enum logic [2:0] {
    REPOSO, DIR_ALE, DIR_HOLD, ESPERA, ACCESO, RECUP, FIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic       w_q, w_d;
  logic [7:0] dato_q, dato_d;
  logic [7:0] dato_lec_q, dato_lec_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       ale_q, ale_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       fin_q, fin_d;
  logic       ocupado_q, ocupado_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    w_d        = w_q;
    dato_d     = dato_q;
    dato_lec_d = dato_lec_q;

    case (state_q)
      REPOSO: begin
        if (activa) begin
          dir_d   = dir;
          w_d     = w;
          dato_d  = dato_esc;
          cnt_d   = CNT_LOAD;
          state_d = DIR_ALE;
        end
      end
      DIR_ALE, DIR_HOLD, ESPERA, ACCESO, RECUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d = CNT_LOAD;
          case (state_q)
            DIR_ALE:  state_d = DIR_HOLD;
            DIR_HOLD: state_d = ESPERA;
            ESPERA:   state_d = ACCESO;
            ACCESO:   state_d = RECUP;
            default:  state_d = FIN;
          endcase
          // Read data is sampled on the final clock of the strobe, just before rd_n rises.
          if (state_q == ACCESO && !w_q) begin
            dato_lec_d = ad_in;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      FIN: begin
        if (!activa) begin
          state_d = REPOSO;
        end
      end
      default: state_d = REPOSO;
    endcase
  end

  // Bus outputs are decoded from the next state so they can be registered without lag.
  always_comb begin
    ale_d     = 1'b0;
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_oe_d   = 1'b0;
    ad_out_d  = 8'h00;
    fin_d     = 1'b0;
    ocupado_d = (state_d != REPOSO);

    case (state_d)
      DIR_ALE: begin
        ale_d    = 1'b1;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_d;
      end
      DIR_HOLD: begin
        ad_oe_d  = 1'b1;
        ad_out_d = dir_d;
      end
      ACCESO: begin
        cs_n_d = 1'b0;
        if (w_d) begin
          wr_n_d   = 1'b0;
          ad_oe_d  = 1'b1;
          ad_out_d = dato_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      RECUP: begin
        if (w_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = dato_d;
        end
      end
      FIN: fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= REPOSO;
      cnt_q      <= 8'd0;
      dir_q      <= 8'h00;
      w_q        <= 1'b0;
      dato_q     <= 8'h00;
      dato_lec_q <= 8'h00;
      ad_out_q   <= 8'h00;
      ad_oe_q    <= 1'b0;
      ale_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      fin_q      <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      w_q        <= w_d;
      dato_q     <= dato_d;
      dato_lec_q <= dato_lec_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      ale_q      <= ale_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      fin_q      <= fin_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign ad_out   = ad_out_q;
  assign ad_oe    = ad_oe_q;
  assign ale      = ale_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign dato_lec = dato_lec_q;
  assign fin      = fin_q;
  assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_ciclo_bus_rtc.sv
// Testbench for ciclo_bus_rtc: one instance with T_PULSO=4 and one with T_PULSO=1,
// compared cycle by cycle against a phase-table model of the bus transaction.
module tb_ciclo_bus_rtc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       activa_s   [2];
  logic       w_s        [2];
  logic [7:0] dir_s      [2];
  logic [7:0] dato_esc_s [2];
  logic [7:0] ad_in_s    [2];
  logic [7:0] ad_out_s   [2];
  logic       ad_oe_s    [2];
  logic       ale_s      [2];
  logic       cs_n_s     [2];
  logic       rd_n_s     [2];
  logic       wr_n_s     [2];
  logic [7:0] dato_lec_s [2];
  logic       fin_s      [2];
  logic       ocupado_s  [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] last_lec [2];
  logic [7:0] prev_lec;
  logic [6:0] obs_bus [$];
  logic [7:0] obs_out [$];
  logic [7:0] obs_lec [$];

  ciclo_bus_rtc #(.T_PULSO(4)) dut4 (
    .clk(clk), .reset(reset), .activa(activa_s[0]), .w(w_s[0]), .dir(dir_s[0]),
    .dato_esc(dato_esc_s[0]), .ad_in(ad_in_s[0]), .ad_out(ad_out_s[0]), .ad_oe(ad_oe_s[0]),
    .ale(ale_s[0]), .cs_n(cs_n_s[0]), .rd_n(rd_n_s[0]), .wr_n(wr_n_s[0]),
    .dato_lec(dato_lec_s[0]), .fin(fin_s[0]), .ocupado(ocupado_s[0])
  );

  ciclo_bus_rtc #(.T_PULSO(1)) dut1 (
    .clk(clk), .reset(reset), .activa(activa_s[1]), .w(w_s[1]), .dir(dir_s[1]),
    .dato_esc(dato_esc_s[1]), .ad_in(ad_in_s[1]), .ad_out(ad_out_s[1]), .ad_oe(ad_oe_s[1]),
    .ale(ale_s[1]), .cs_n(cs_n_s[1]), .rd_n(rd_n_s[1]), .wr_n(wr_n_s[1]),
    .dato_lec(dato_lec_s[1]), .fin(fin_s[1]), .ocupado(ocupado_s[1])
  );

  // Bus-level invariants, watched on every cycle of both instances while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if ((rd_n_s[d] === 1'b0 && wr_n_s[d] === 1'b0) ||
            (ad_oe_s[d] === 1'b1 && rd_n_s[d] === 1'b0)) begin
          n_bad++;
          $display("[TB] FAIL invariant dut%0d rd_n=%b wr_n=%b ad_oe=%b (need no rd/wr overlap, no oe while reading)",
                   d, rd_n_s[d], wr_n_s[d], ad_oe_s[d]);
        end
      end
    end
  end

  // Expected {ale,cs_n,rd_n,wr_n,ad_oe,fin,ocupado} k cycles after acceptance:
  // five phases of tp cycles, then FIN for hold+1 cycles, then idle.
  function automatic logic [6:0] exp_bus(int tp, int k, logic wv, int hold);
    int   p;
    logic e_ale, e_cs, e_rd, e_wr, e_oe, e_fin, e_oc;
    e_ale = 1'b0; e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1;
    e_oe  = 1'b0; e_fin = 1'b0; e_oc = 1'b1;
    if (k < 5 * tp) begin
      p     = k / tp;
      e_ale = (p == 0);
      e_cs  = (p != 3);
      e_rd  = !(p == 3 && !wv);
      e_wr  = !(p == 3 && wv);
      e_oe  = (p < 2) || (wv && p >= 3);
    end else if (k <= 5 * tp + hold) begin
      e_fin = 1'b1;
    end else begin
      e_oc = 1'b0;
    end
    return {e_ale, e_cs, e_rd, e_wr, e_oe, e_fin, e_oc};
  endfunction

  // Returns {care, value} for ad_out; it only matters when driven, or in ESPERA.
  function automatic logic [8:0] exp_out(int tp, int k, logic wv, logic [7:0] dv, logic [7:0] dat);
    int p;
    if (k >= 5 * tp) return 9'h000;
    p = k / tp;
    if (p < 2)  return {1'b1, dv};
    if (p == 2) return {1'b1, 8'h00};
    if (wv)     return {1'b1, dat};
    return 9'h000;
  endfunction

  function automatic logic [7:0] exp_lec(int tp, int k, logic wv, logic [7:0] adi, logic [7:0] prev);
    return (!wv && k >= 4 * tp) ? adi : prev;
  endfunction

  // Runs one transaction on instance d and records outputs from the cycle after
  // acceptance until one cycle after fin has dropped. Request inputs are scrambled
  // right after acceptance; ad_in carries adi only while the read strobe is low.
  task automatic drive_txn(input int d, input int tp, input logic wv, input logic [7:0] dv,
                           input logic [7:0] dat, input logic [7:0] adi,
                           input bit drop, input int hold);
    int last;
    obs_bus.delete();
    obs_out.delete();
    obs_lec.delete();
    prev_lec      = last_lec[d];
    w_s[d]        = wv;
    dir_s[d]      = dv;
    dato_esc_s[d] = dat;
    activa_s[d]   = 1'b1;
    last = 5 * tp + hold + 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      obs_bus.push_back({ale_s[d], cs_n_s[d], rd_n_s[d], wr_n_s[d], ad_oe_s[d], fin_s[d], ocupado_s[d]});
      obs_out.push_back(ad_out_s[d]);
      obs_lec.push_back(dato_lec_s[d]);
      if (k == 0) begin
        w_s[d]        = ~wv;
        dir_s[d]      = 8'($urandom);
        dato_esc_s[d] = 8'($urandom);
        if (drop) activa_s[d] = 1'b0;
      end
      ad_in_s[d] = (k < 5 * tp && k / tp == 3) ? adi : 8'($urandom);
      if (k == 5 * tp + hold) activa_s[d] = 1'b0;
    end
    if (!wv) last_lec[d] = adi;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      activa_s[d] = 1'b0; w_s[d] = 1'b0; dir_s[d] = 8'h00;
      dato_esc_s[d] = 8'h00; ad_in_s[d] = 8'($urandom);
      last_lec[d] = 8'h00;
    end
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({ale_s[d], cs_n_s[d], rd_n_s[d], wr_n_s[d], ad_oe_s[d], fin_s[d], ocupado_s[d]} !== 7'b0111000 ||
          ad_out_s[d] !== 8'h00 || dato_lec_s[d] !== 8'h00) begin
        n_bad++;
        $display("[TB] FAIL async_reset dut%0d bus=%b ad_out=%h lec=%h need 0111000/00/00",
                 d, {ale_s[d], cs_n_s[d], rd_n_s[d], wr_n_s[d], ad_oe_s[d], fin_s[d], ocupado_s[d]},
                 ad_out_s[d], dato_lec_s[d]);
      end
    end
    activa_s[1] = 1'b1; w_s[1] = 1'b1; dir_s[1] = 8'h5A; dato_esc_s[1] = 8'hC3;
    @(negedge clk);
    n_cmp++;
    if (ale_s[1] !== 1'b0 || ocupado_s[1] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_hold ale=%b ocupado=%b need 0/0", ale_s[1], ocupado_s[1]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ale_s[1] !== 1'b1 || ad_out_s[1] !== 8'h5A || ocupado_s[1] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL release_accept ale=%b ad_out=%h ocupado=%b need 1/5a/1",
               ale_s[1], ad_out_s[1], ocupado_s[1]);
    end
    n_cmp++;
    if (ocupado_s[0] !== 1'b0 || cs_n_s[0] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL idle_after_reset ocupado=%b cs_n=%b need 0/1", ocupado_s[0], cs_n_s[0]);
    end
    activa_s[1] = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (fin_s[1] !== 1'b0 || ocupado_s[1] !== 1'b0 || dato_lec_s[1] !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL first_txn_end fin=%b ocupado=%b lec=%h need 0/0/00",
               fin_s[1], ocupado_s[1], dato_lec_s[1]);
    end
  endtask

  task automatic test_write();
    logic [8:0] eo;
    drive_txn(0, 4, 1'b1, 8'h23, 8'h59, 8'($urandom), 1'b0, 0);
    for (int k = 0; k < obs_bus.size(); k++) begin
      eo = exp_out(4, k, 1'b1, 8'h23, 8'h59);
      n_cmp++;
      if (obs_bus[k] !== exp_bus(4, k, 1'b1, 0) || (eo[8] && obs_out[k] !== eo[7:0]) ||
          obs_lec[k] !== exp_lec(4, k, 1'b1, 8'h00, prev_lec)) begin
        n_bad++;
        $display("[TB] FAIL write k=%0d bus=%b out=%h lec=%h need bus=%b out=%h lec=%h",
                 k, obs_bus[k], obs_out[k], obs_lec[k], exp_bus(4, k, 1'b1, 0), eo[7:0], prev_lec);
      end
    end
  endtask

  task automatic test_read();
    logic [8:0] eo;
    drive_txn(0, 4, 1'b0, 8'h21, 8'hEE, 8'h47, 1'b0, 0);
    for (int k = 0; k < obs_bus.size(); k++) begin
      eo = exp_out(4, k, 1'b0, 8'h21, 8'hEE);
      n_cmp++;
      if (obs_bus[k] !== exp_bus(4, k, 1'b0, 0) || (eo[8] && obs_out[k] !== eo[7:0]) ||
          obs_lec[k] !== exp_lec(4, k, 1'b0, 8'h47, prev_lec)) begin
        n_bad++;
        $display("[TB] FAIL read k=%0d bus=%b out=%h lec=%h need bus=%b out=%h lec=%h",
                 k, obs_bus[k], obs_out[k], obs_lec[k], exp_bus(4, k, 1'b0, 0), eo[7:0],
                 exp_lec(4, k, 1'b0, 8'h47, prev_lec));
      end
    end
  endtask

  task automatic test_held_request();
    logic [8:0] eo;
    drive_txn(0, 4, 1'b1, 8'h3C, 8'h81, 8'($urandom), 1'b0, 3);
    for (int k = 0; k < obs_bus.size(); k++) begin
      eo = exp_out(4, k, 1'b1, 8'h3C, 8'h81);
      n_cmp++;
      if (obs_bus[k] !== exp_bus(4, k, 1'b1, 3) || (eo[8] && obs_out[k] !== eo[7:0])) begin
        n_bad++;
        $display("[TB] FAIL held k=%0d bus=%b out=%h need bus=%b out=%h",
                 k, obs_bus[k], obs_out[k], exp_bus(4, k, 1'b1, 3), eo[7:0]);
      end
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ale_s[0] !== 1'b0 || ocupado_s[0] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL held_no_retrigger ale=%b ocupado=%b need 0/0", ale_s[0], ocupado_s[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] eo;
    logic [7:0] addr [2];
    logic       wv   [2];
    logic [7:0] adi;
    addr[0] = 8'h11; addr[1] = 8'h12;
    wv[0]   = 1'b1;  wv[1]   = 1'b0;
    adi     = 8'h9D;
    for (int t = 0; t < 2; t++) begin
      drive_txn(1, 1, wv[t], addr[t], 8'hA5, adi, 1'b0, 0);
      for (int k = 0; k < obs_bus.size(); k++) begin
        eo = exp_out(1, k, wv[t], addr[t], 8'hA5);
        n_cmp++;
        if (obs_bus[k] !== exp_bus(1, k, wv[t], 0) || (eo[8] && obs_out[k] !== eo[7:0]) ||
            obs_lec[k] !== exp_lec(1, k, wv[t], adi, prev_lec)) begin
          n_bad++;
          $display("[TB] FAIL b2b t=%0d k=%0d bus=%b out=%h lec=%h need bus=%b out=%h lec=%h",
                   t, k, obs_bus[k], obs_out[k], obs_lec[k], exp_bus(1, k, wv[t], 0), eo[7:0],
                   exp_lec(1, k, wv[t], adi, prev_lec));
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    w_s[0] = 1'b1; dir_s[0] = 8'h2F; dato_esc_s[0] = 8'h66; activa_s[0] = 1'b1;
    repeat (13) @(negedge clk);
    n_cmp++;
    if (cs_n_s[0] !== 1'b0 || wr_n_s[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midop_in_acceso cs_n=%b wr_n=%b need 0/0", cs_n_s[0], wr_n_s[0]);
    end
    activa_s[0] = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (wr_n_s[0] !== 1'b1 || cs_n_s[0] !== 1'b1 || ad_oe_s[0] !== 1'b0 ||
        fin_s[0] !== 1'b0 || ale_s[0] !== 1'b0 || ocupado_s[0] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL midop_abort wr_n=%b cs_n=%b ad_oe=%b fin=%b ale=%b ocupado=%b need 1/1/0/0/0/0",
               wr_n_s[0], cs_n_s[0], ad_oe_s[0], fin_s[0], ale_s[0], ocupado_s[0]);
    end
    last_lec[0] = 8'h00;
    last_lec[1] = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (25) begin
      @(negedge clk);
      n_cmp++;
      if (fin_s[0] !== 1'b0 || ocupado_s[0] !== 1'b0 || cs_n_s[0] !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL midop_quiet fin=%b ocupado=%b cs_n=%b need 0/0/1",
                 fin_s[0], ocupado_s[0], cs_n_s[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] eo;
    int         d, tp, hold;
    logic       wv;
    bit         drop;
    logic [7:0] dv, dat, adi;
    for (int i = 0; i < 10; i++) begin
      d    = i % 2;
      tp   = (d == 0) ? 4 : 1;
      wv   = 1'($urandom);
      drop = 1'($urandom);
      hold = drop ? 0 : int'($urandom_range(0, 2));
      dv   = 8'($urandom);
      dat  = 8'($urandom);
      adi  = 8'($urandom);
      drive_txn(d, tp, wv, dv, dat, adi, drop, hold);
      for (int k = 0; k < obs_bus.size(); k++) begin
        eo = exp_out(tp, k, wv, dv, dat);
        n_cmp++;
        if (obs_bus[k] !== exp_bus(tp, k, wv, hold) || (eo[8] && obs_out[k] !== eo[7:0]) ||
            obs_lec[k] !== exp_lec(tp, k, wv, adi, prev_lec)) begin
          n_bad++;
          $display("[TB] FAIL random i=%0d k=%0d bus=%b out=%h lec=%h need bus=%b out=%h lec=%h",
                   i, k, obs_bus[k], obs_out[k], obs_lec[k], exp_bus(tp, k, wv, hold), eo[7:0],
                   exp_lec(tp, k, wv, adi, prev_lec));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_held_request();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
